// File: rtl/tron_pkg.sv
// tron_pkg: shared constants for the tron tile map.
// Holds the glyph codes, the heading encoding, the map geometry
// defaults and the tile address helper.
package tron_pkg;

  // Map geometry defaults
  localparam logic [15:0] TRON_BASE = 16'd40000;
  localparam int          TRON_COLS = 160;
  localparam int          TRON_ROWS = 120;

  // Heading encoding as it arrives on req_dir
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dirT;

  // Glyph codes live in 0..59
  typedef logic [5:0] glyphT;

  localparam glyphT GLYPH_EMPTY = 6'd0;

  // Blue set
  localparam glyphT GLYPH_BLUE_TRAIL_H = 6'd3;
  localparam glyphT GLYPH_BLUE_TRAIL_V = 6'd4;
  localparam glyphT GLYPH_BLUE_RD_UL   = 6'd6;
  localparam glyphT GLYPH_BLUE_RU_DL   = 6'd7;
  localparam glyphT GLYPH_BLUE_LD_UR   = 6'd8;
  localparam glyphT GLYPH_BLUE_LU_DR   = 6'd9;
  localparam glyphT GLYPH_BLUE_BIKE_H  = 6'd11;
  localparam glyphT GLYPH_BLUE_BIKE_V  = 6'd21;

  // Yellow set
  localparam glyphT GLYPH_YEL_TRAIL_H  = 6'd34;
  localparam glyphT GLYPH_YEL_TRAIL_V  = 6'd35;
  localparam glyphT GLYPH_YEL_RD_UL    = 6'd37;
  localparam glyphT GLYPH_YEL_RU_DL    = 6'd38;
  localparam glyphT GLYPH_YEL_LD_UR    = 6'd39;
  localparam glyphT GLYPH_YEL_LU_DR    = 6'd40;
  localparam glyphT GLYPH_YEL_BIKE_H   = 6'd41;
  localparam glyphT GLYPH_YEL_BIKE_V   = 6'd51;

  // Word address of a map cell, 16-bit wraparound. The 160-wide map uses
  // the shift-add form so no multiplier is needed.
  function automatic logic [15:0] tileAddr(input logic [15:0] base,
                                           input logic [7:0]  row,
                                           input logic [7:0]  col,
                                           input int          cols);
    logic [15:0] rowW;
    logic [15:0] rowOff;
    rowW = {8'd0, row};
    if (cols == 160) rowOff = (rowW << 7) + (rowW << 5);
    else             rowOff = rowW * 16'(cols);
    return base + rowOff + {8'd0, col};
  endfunction

endpackage

// File: rtl/tile_glyph_sel.sv
// tile_glyph_sel: picks the trail glyph left behind at the old cell and the
// bike glyph drawn at the new cell from player and old/new heading.
module tile_glyph_sel
  import tron_pkg::*;
(
  input  logic       player,
  input  logic [1:0] oldDir,
  input  logic [1:0] newDir,
  output glyphT      trailGlyph,
  output glyphT      bikeGlyph
);

  typedef enum logic [2:0] {
    K_V, K_H, K_RD_UL, K_RU_DL, K_LD_UR, K_LU_DR
  } kindT;

  kindT trailKind;

  // Classify the turn; same axis (straight or reversal) keeps the old axis
  always_comb begin
    trailKind = K_H;
    if (oldDir[1] == newDir[1]) begin
      trailKind = oldDir[1] ? K_H : K_V;
    end else begin
      case ({oldDir, newDir})
        {DIR_RIGHT, DIR_DOWN}, {DIR_UP, DIR_LEFT}:   trailKind = K_RD_UL;
        {DIR_RIGHT, DIR_UP},   {DIR_DOWN, DIR_LEFT}: trailKind = K_RU_DL;
        {DIR_LEFT, DIR_DOWN},  {DIR_UP, DIR_RIGHT}:  trailKind = K_LD_UR;
        {DIR_LEFT, DIR_UP},    {DIR_DOWN, DIR_RIGHT}: trailKind = K_LU_DR;
        default:                                     trailKind = K_H;
      endcase
    end
  end

  // Map the turn class and heading onto the player's glyph set
  always_comb begin
    trailGlyph = GLYPH_EMPTY;
    case (trailKind)
      K_V:     trailGlyph = player ? GLYPH_YEL_TRAIL_V : GLYPH_BLUE_TRAIL_V;
      K_H:     trailGlyph = player ? GLYPH_YEL_TRAIL_H : GLYPH_BLUE_TRAIL_H;
      K_RD_UL: trailGlyph = player ? GLYPH_YEL_RD_UL   : GLYPH_BLUE_RD_UL;
      K_RU_DL: trailGlyph = player ? GLYPH_YEL_RU_DL   : GLYPH_BLUE_RU_DL;
      K_LD_UR: trailGlyph = player ? GLYPH_YEL_LD_UR   : GLYPH_BLUE_LD_UR;
      K_LU_DR: trailGlyph = player ? GLYPH_YEL_LU_DR   : GLYPH_BLUE_LU_DR;
      default: trailGlyph = GLYPH_EMPTY;
    endcase
    if (newDir[1]) bikeGlyph = player ? GLYPH_YEL_BIKE_H : GLYPH_BLUE_BIKE_H;
    else           bikeGlyph = player ? GLYPH_YEL_BIKE_V : GLYPH_BLUE_BIKE_V;
  end

endmodule

// File: rtl/tile_writer.sv
// tile_writer: turns bike move requests into tile-map writes (trail glyph at
// the previous cell, bike glyph at the new cell), one word per cycle.
// Optional feature: define TILE_WRITER_CLEAR_EN to build the CLEAR command,
// which blanks the whole map and forgets both bikes.
module tile_writer
  import tron_pkg::*;
#(
  parameter logic [15:0] BASE = TRON_BASE,
  parameter int          COLS = TRON_COLS,
  parameter int          ROWS = TRON_ROWS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_player,
  input  logic [7:0]  req_col,
  input  logic [7:0]  req_row,
  input  logic [1:0]  req_dir,
  input  logic        clear_req,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_TRAIL = 2'd1,
    WR_BIKE  = 2'd2
`ifdef TILE_WRITER_CLEAR_EN
    , CLEAR  = 2'd3
`endif
  } stateT;

  stateT       stateReg, stateNext;
  logic [15:0] addrReg, addrNext;
  logic [15:0] wdataReg, wdataNext;
  logic        errReg, errNext;

  // Request captured at accept, used for the rest of the move
  logic        curPlayerReg;
  logic [7:0]  curColReg, curRowReg;
  logic [1:0]  curDirReg;

  // Per-player history
  logic        validReg [2];
  logic [7:0]  colReg   [2];
  logic [7:0]  rowReg   [2];
  logic [1:0]  dirReg   [2];

  logic        clearAccept, accept, outOfRange, playerValid, completeMove;
  logic        selPlayer;
  logic [7:0]  selCol, selRow;
  logic [1:0]  selDir, oldDir;
  logic [15:0] trailAddr, bikeAddr;
  glyphT       trailGlyph, bikeGlyph;

`ifdef TILE_WRITER_CLEAR_EN
  localparam int          CELLS     = COLS * ROWS;
  localparam logic [14:0] LAST_CELL = 15'(CELLS - 1);
  logic [14:0] clearCntReg, clearCntNext;
`else
  logic unusedClearReq;
  assign unusedClearReq = clear_req;
`endif

  // Clear wins over a move request arriving in the same IDLE cycle
  always_comb begin
    clearAccept = 1'b0;
`ifdef TILE_WRITER_CLEAR_EN
    clearAccept = (stateReg == IDLE) && clear_req;
`endif
  end

  assign req_ready    = (stateReg == IDLE) && !clearAccept;
  assign accept       = req_valid && req_ready;
  assign outOfRange   = (int'(req_col) >= COLS) || (int'(req_row) >= ROWS);
  assign playerValid  = validReg[req_player];
  assign completeMove = (stateReg == WR_BIKE);

  // Live request while idle, latched request once a move is under way
  always_comb begin
    selPlayer = curPlayerReg;
    selCol    = curColReg;
    selRow    = curRowReg;
    selDir    = curDirReg;
    if (stateReg == IDLE) begin
      selPlayer = req_player;
      selCol    = req_col;
      selRow    = req_row;
      selDir    = req_dir;
    end
  end

  assign oldDir    = dirReg[selPlayer];
  assign trailAddr = tileAddr(BASE, rowReg[req_player], colReg[req_player], COLS);
  assign bikeAddr  = tileAddr(BASE, selRow, selCol, COLS);

  tile_glyph_sel uGlyph (
    .player     (selPlayer),
    .oldDir     (oldDir),
    .newDir     (selDir),
    .trailGlyph (trailGlyph),
    .bikeGlyph  (bikeGlyph)
  );

  // Next state and the next registered write word (zero when not writing)
  always_comb begin
    stateNext = stateReg;
    addrNext  = '0;
    wdataNext = '0;
    errNext   = 1'b0;
`ifdef TILE_WRITER_CLEAR_EN
    clearCntNext = clearCntReg;
`endif
    case (stateReg)
      IDLE: begin
`ifdef TILE_WRITER_CLEAR_EN
        if (clearAccept) begin
          stateNext    = CLEAR;
          addrNext     = BASE;
          wdataNext    = 16'(GLYPH_EMPTY);
          clearCntNext = '0;
        end else
`endif
        if (accept) begin
          if (outOfRange) begin
            errNext = 1'b1;
          end else if (playerValid) begin
            stateNext = WR_TRAIL;
            addrNext  = trailAddr;
            wdataNext = 16'(trailGlyph);
          end else begin
            stateNext = WR_BIKE;
            addrNext  = bikeAddr;
            wdataNext = 16'(bikeGlyph);
          end
        end
      end
      WR_TRAIL: begin
        stateNext = WR_BIKE;
        addrNext  = bikeAddr;
        wdataNext = 16'(bikeGlyph);
      end
      WR_BIKE: begin
        stateNext = IDLE;
      end
`ifdef TILE_WRITER_CLEAR_EN
      CLEAR: begin
        if (clearCntReg == LAST_CELL) begin
          stateNext = IDLE;
        end else begin
          clearCntNext = clearCntReg + 15'd1;
          addrNext     = addrReg + 16'd1;
          wdataNext    = 16'(GLYPH_EMPTY);
        end
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

  // State, write port and error pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
      addrReg  <= '0;
      wdataReg <= '0;
      errReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      addrReg  <= addrNext;
      wdataReg <= wdataNext;
      errReg   <= errNext;
    end
  end

`ifdef TILE_WRITER_CLEAR_EN
  // Clear sweep cell counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) clearCntReg <= '0;
    else       clearCntReg <= clearCntNext;
  end
`endif

  // Capture the request on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curPlayerReg <= 1'b0;
      curColReg    <= '0;
      curRowReg    <= '0;
      curDirReg    <= '0;
    end else if (accept) begin
      curPlayerReg <= req_player;
      curColReg    <= req_col;
      curRowReg    <= req_row;
      curDirReg    <= req_dir;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gPlayer
      // Commit the finished move into this player's history; clear forgets it
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          validReg[gi] <= 1'b0;
          colReg[gi]   <= '0;
          rowReg[gi]   <= '0;
          dirReg[gi]   <= '0;
        end else if (clearAccept) begin
          validReg[gi] <= 1'b0;
        end else if (completeMove && (curPlayerReg == 1'(gi))) begin
          validReg[gi] <= 1'b1;
          colReg[gi]   <= curColReg;
          rowReg[gi]   <= curRowReg;
          dirReg[gi]   <= curDirReg;
        end
      end
    end
  endgenerate

  assign busy      = (stateReg != IDLE);
  assign mem_we    = (stateReg != IDLE);
  assign mem_addr  = addrReg;
  assign mem_wdata = wdataReg;
  assign err       = errReg;
`ifdef TILE_WRITER_CLEAR_EN
  assign done = (stateReg == WR_BIKE) ||
                ((stateReg == CLEAR) && (clearCntReg == LAST_CELL));
`else
  assign done = (stateReg == WR_BIKE);
`endif

endmodule

// File: doc/tile_writer.md
TILE_WRITER -- requirements
Module: tile_writer

Interface
REQ-001 Parameters: BASE, 16'd40000, tile-map base word address; COLS, 160, tiles per row; ROWS, 120, rows in map.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  move request present.
REQ-005 req_ready  out  1  block can accept a request this cycle.
REQ-006 req_player  in  1  0 = blue, 1 = yellow.
REQ-007 req_col  in  8  new bike column; req_row  in  8  new bike row.
REQ-008 req_dir  in  2  new heading: 00 up, 01 down, 10 left, 11 right.
REQ-009 clear_req  in  1  clear-map command, level-sampled in IDLE.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 done  out  1  one-cycle pulse on the final write of a move or clear.
REQ-012 err  out  1  one-cycle pulse when an out-of-range request is accepted.
REQ-013 mem_addr  out  16  word address to exmem write port; mem_wdata  out  16  glyph code; mem_we  out  1  write strobe, one word per cycle.

Function
REQ-014 States: IDLE, WR_TRAIL, WR_BIKE, CLEAR; req_ready = (state == IDLE) and not (clear accepted this cycle).
REQ-015 Handshake: request accepted on clk edge with req_valid & req_ready; inputs latched then, ignored afterwards.
REQ-016 Address = BASE + row*COLS + col, 16-bit wraparound, row*160 formed as (row<<7)+(row<<5).
REQ-017 col >= COLS or row >= ROWS: accept, no memory write, err pulse next cycle, stay IDLE, stored state unchanged.
REQ-018 Per player, registers hold last col, row, heading and a valid flag.
REQ-019 Valid request with player valid flag set: IDLE -> WR_TRAIL (write trail glyph at stored cell) -> WR_BIKE (write bike glyph at new cell, done) -> IDLE; mem_we high exactly those two cycles.
REQ-020 Valid flag clear: IDLE -> WR_BIKE directly; no trail write; flag set on completion.
REQ-021 Trail glyph, blue/yellow: same heading up/down 4/35, left/right 3/34; reversal (new opposite old) uses straight glyph of old axis.
REQ-022 Corners (old->new): right->down, up->left = 6/37; right->up, down->left = 7/38; left->down, up->right = 8/39; left->up, down->right = 9/40.
REQ-023 Bike glyph: heading left/right 11/41, up/down 21/51.
REQ-024 Latency: first write 1 cycle after accept; req_ready again 3 cycles after accept (2 for first move).
REQ-025 mem_addr/mem_wdata are registered; drive 0 when mem_we low.

Reset
REQ-026 Reset forces IDLE; mem_we, done, err, busy = 0; mem_addr, mem_wdata = 0; both valid flags, positions, headings = 0.
REQ-027 Reset mid-write or mid-clear: mem_we drops asynchronously; partial clear is not resumed.

Configuration
REQ-028 Macro TILE_WRITER_CLEAR_EN: defined -> clear_req in IDLE enters CLEAR, writes glyph 0 to BASE .. BASE+COLS*ROWS-1 one word/cycle (19200 cycles), done on last write, both valid flags cleared; clear_req wins over simultaneous req_valid.
REQ-029 Undefined -> clear_req ignored, CLEAR state absent, req_ready never depends on clear_req.

Structure
REQ-030 Shared package tron_pkg holds glyph code constants (0-59), direction encoding and COLS/ROWS/BASE defaults.
REQ-031 Sub-module tile_glyph_sel (pure combinational: player, old heading, new heading -> trail and bike glyph codes); FSM, address math and per-player registers in tile_writer.

Verification
REQ-032 After reset, blue req col 5 row 2 dir right -> one write addr 40325 data 11, done, ready 2 cycles after accept.
REQ-033 Then blue col 6 row 2 dir right -> writes (40325, 3) then (40326, 11).
REQ-034 Then blue col 6 row 3 dir down -> writes (40326, 6) then (40486, 21).
REQ-035 Yellow req col 160 row 0 -> no mem_we, err pulse, yellow valid flag stays 0.
REQ-036 TILE_WRITER_CLEAR_EN, clear_req and req_valid same cycle -> 19200 writes of 0 from 40000 to 59199, done on last, request held until IDLE, next move has no trail write.
REQ-037 Reset asserted during WR_TRAIL -> mem_we low immediately, IDLE, req_ready high on first edge after reset release.
